// File: rtl/uart_rx_fifo_if.sv
// uart_rx_fifo_if: groups the receiver-side frame signals and the host-side
// FIFO read port of uart_rx_fifo.
//   rx_busy/rx_ack/rx_data : UART receiver status and byte
//   rd_en/clr_ovf          : host pop request and overflow clear
//   rd_data/empty/full/count/overflow : FIFO state seen by the host
// Modports: master drives the receiver and host inputs, slave is the FIFO.
interface uart_rx_fifo_if #(
  parameter int unsigned ADDR_W = 4
);
  logic              rx_busy;
  logic              rx_ack;
  logic [7:0]        rx_data;
  logic              rd_en;
  logic              clr_ovf;
  logic [7:0]        rd_data;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overflow;

  modport master (
    output rx_busy, rx_ack, rx_data, rd_en, clr_ovf,
    input  rd_data, empty, full, count, overflow
  );

  modport slave (
    input  rx_busy, rx_ack, rx_data, rd_en, clr_ovf,
    output rd_data, empty, full, count, overflow
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// uart_rx_fifo: downstream stage of the UART receiver. Each completed frame
// with a valid stop bit (BUSY falling while ACK is high) pushes the received
// byte into a first-word-fall-through byte FIFO that the host drains at its
// own pace. A byte arriving while the FIFO is full is dropped and a sticky
// overflow flag is raised until clr_ovf.
// Ports:
//   clk    : system clock, same domain as the receiver
//   rst_n  : asynchronous active-low reset
//   bus    : uart_rx_fifo_if.slave (receiver inputs, host pop/clear,
//            rd_data/empty/full/count/overflow outputs)
module uart_rx_fifo #(
  parameter int unsigned DEPTH  = 16,
  parameter int unsigned ADDR_W = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  uart_rx_fifo_if.slave   bus
);

  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);

  logic              busy_q,     busy_d;
  logic              cap_pend_q, cap_pend_d;
  logic [ADDR_W-1:0] wr_ptr_q,   wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q,   rd_ptr_d;
  logic [ADDR_W:0]   count_q,    count_d;
  logic              empty_q,    empty_d;
  logic              full_q,     full_d;
  logic              ovf_q,      ovf_d;
  logic [7:0]        mem_q [DEPTH];

  logic fall;
  logic push;
  logic pop;
  logic wr_ok;

  always_comb begin
    busy_d     = bus.rx_busy;
    // Only a BUSY falling edge with ACK high marks a good frame; ACK is a
    // level and would otherwise re-push the same byte every cycle.
    fall       = busy_q & ~bus.rx_busy & bus.rx_ack;
    // DATA becomes valid one cycle after the fall, so capture one edge later.
    cap_pend_d = fall;
    push       = cap_pend_q;
    pop        = bus.rd_en & ~empty_q;
    // When full, a same-edge pop frees the slot before the write lands.
    wr_ok      = push & (~full_q | pop);

    wr_ptr_d = wr_ok ? wr_ptr_q + PTR_ONE : wr_ptr_q;
    rd_ptr_d = pop   ? rd_ptr_q + PTR_ONE : rd_ptr_q;

    count_d = count_q;
    unique case ({wr_ok, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase

    empty_d = (count_d == '0);
    full_d  = (count_d == CNT_FULL);

    // Setting the flag takes priority over a same-cycle clear.
    ovf_d = ovf_q;
    if (push && full_q && !pop) begin
      ovf_d = 1'b1;
    end else if (bus.clr_ovf) begin
      ovf_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q     <= 1'b0;
      cap_pend_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      busy_q     <= busy_d;
      cap_pend_q <= cap_pend_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      empty_q    <= empty_d;
      full_q     <= full_d;
      ovf_q      <= ovf_d;
    end
  end

  // Storage has no reset; empty gates what the host can observe.
  always_ff @(posedge clk) begin
    if (wr_ok) begin
      mem_q[wr_ptr_q] <= bus.rx_data;
    end
  end

  assign bus.rd_data  = empty_q ? '0 : mem_q[rd_ptr_q];
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;
  assign bus.overflow = ovf_q;

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a per-cycle vector table for reset,
// single-frame, bad-stop-bit and ACK-level cases, then hand-written
// sequences for fill/overflow, pointer wrap, push+pop while full and reset
// during a pending capture.
module tb_uart_rx_fifo;

  logic clk;
  logic rst_n;

  uart_rx_fifo_if #(.ADDR_W(4)) bus ();

  uart_rx_fifo #(.DEPTH(16), .ADDR_W(4)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       busy;
    logic       ack;
    logic [7:0] data;
    logic       rd;
    logic       clr;
    logic [4:0] cnt;
    logic       emp;
    logic       ful;
    logic       ovf;
    logic [7:0] rdd;
  } vec_t;

  localparam int unsigned NVEC = 18;
  vec_t tbl [NVEC];

  int unsigned n_vec;
  int unsigned n_err;

  function automatic vec_t mk(input logic b, input logic a, input logic [7:0] d,
                              input logic r, input logic c, input logic [4:0] cnt,
                              input logic emp, input logic ful, input logic ovf,
                              input logic [7:0] rdd);
    vec_t v;
    v.busy = b; v.ack = a; v.data = d; v.rd = r; v.clr = c;
    v.cnt = cnt; v.emp = emp; v.ful = ful; v.ovf = ovf; v.rdd = rdd;
    return v;
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // Drive one cycle of inputs at the falling edge, return just after the rising edge.
  task automatic step(input logic b, input logic a, input logic [7:0] d,
                      input logic r, input logic c);
    @(negedge clk);
    bus.rx_busy = b;
    bus.rx_ack  = a;
    bus.rx_data = d;
    bus.rd_en   = r;
    bus.clr_ovf = c;
    @(posedge clk);
    #1;
  endtask

  // One good frame: BUSY high, falls with ACK high, DATA valid on the next cycle.
  task automatic frame(input logic [7:0] d, input logic rd_on_push);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, d,     rd_on_push, 1'b0);
  endtask

  task automatic pop_check(input string name, input logic [7:0] exp);
    check(name, 32'(bus.rd_data), 32'(exp));
    step(1'b0, 1'b1, 8'h00, 1'b1, 1'b0);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;

    tbl[0]  = mk(0,1,8'h00,0,0, 5'd0,1,0,0,8'h00);
    tbl[1]  = mk(0,1,8'h00,0,0, 5'd0,1,0,0,8'h00);
    tbl[2]  = mk(1,0,8'h00,0,0, 5'd0,1,0,0,8'h00);
    tbl[3]  = mk(1,1,8'h00,0,0, 5'd0,1,0,0,8'h00);
    tbl[4]  = mk(0,1,8'h00,0,0, 5'd0,1,0,0,8'h00);
    tbl[5]  = mk(0,1,8'hA5,0,0, 5'd1,0,0,0,8'hA5);
    tbl[6]  = mk(0,1,8'h00,0,0, 5'd1,0,0,0,8'hA5);
    tbl[7]  = mk(0,1,8'h00,1,0, 5'd0,1,0,0,8'h00);
    tbl[8]  = mk(0,1,8'h00,1,0, 5'd0,1,0,0,8'h00);
    tbl[9]  = mk(1,0,8'h00,0,0, 5'd0,1,0,0,8'h00);
    tbl[10] = mk(0,0,8'hEE,0,0, 5'd0,1,0,0,8'h00);
    tbl[11] = mk(0,0,8'hEE,0,0, 5'd0,1,0,0,8'h00);
    tbl[12] = mk(0,1,8'hEE,0,0, 5'd0,1,0,0,8'h00);
    tbl[13] = mk(1,0,8'h00,0,0, 5'd0,1,0,0,8'h00);
    tbl[14] = mk(0,1,8'h00,0,0, 5'd0,1,0,0,8'h00);
    tbl[15] = mk(0,1,8'h3C,0,0, 5'd1,0,0,0,8'h3C);
    tbl[16] = mk(0,1,8'h00,0,1, 5'd1,0,0,0,8'h3C);
    tbl[17] = mk(0,1,8'h00,1,0, 5'd0,1,0,0,8'h00);

    // Reset with random inputs.
    rst_n = 1'b0;
    bus.rx_busy = 1'($urandom);
    bus.rx_ack  = 1'($urandom);
    bus.rx_data = 8'($urandom);
    bus.rd_en   = 1'($urandom);
    bus.clr_ovf = 1'($urandom);
    repeat (3) @(posedge clk);
    #1;
    check("rst_count", 32'(bus.count), 32'd0);
    check("rst_empty", 32'(bus.empty), 32'd1);
    check("rst_full",  32'(bus.full),  32'd0);
    check("rst_ovf",   32'(bus.overflow), 32'd0);
    check("rst_rdata", 32'(bus.rd_data), 32'h00);
    @(negedge clk);
    bus.rx_busy = 1'b0;
    bus.rx_ack  = 1'b1;
    bus.rx_data = 8'h00;
    bus.rd_en   = 1'b0;
    bus.clr_ovf = 1'b0;
    rst_n = 1'b1;

    for (int i = 0; i < int'(NVEC); i++) begin
      step(tbl[i].busy, tbl[i].ack, tbl[i].data, tbl[i].rd, tbl[i].clr);
      n_vec++;
      if ({bus.count, bus.empty, bus.full, bus.overflow, bus.rd_data} !==
          {tbl[i].cnt, tbl[i].emp, tbl[i].ful, tbl[i].ovf, tbl[i].rdd}) begin
        n_err++;
        $display("FAIL vec%0d: got cnt=%0d emp=%b ful=%b ovf=%b rd=%h expected cnt=%0d emp=%b ful=%b ovf=%b rd=%h",
                 i, bus.count, bus.empty, bus.full, bus.overflow, bus.rd_data,
                 tbl[i].cnt, tbl[i].emp, tbl[i].ful, tbl[i].ovf, tbl[i].rdd);
      end
    end

    // Fill and overflow.
    for (int i = 0; i < 16; i++) frame(8'(i), 1'b0);
    check("fill_count", 32'(bus.count), 32'd16);
    check("fill_full",  32'(bus.full),  32'd1);
    check("fill_ovf",   32'(bus.overflow), 32'd0);
    frame(8'hFF, 1'b0);
    check("ovf_set",    32'(bus.overflow), 32'd1);
    check("ovf_count",  32'(bus.count), 32'd16);
    for (int i = 0; i < 16; i++) pop_check("drain", 8'(i));
    check("drain_empty", 32'(bus.empty), 32'd1);
    check("drain_rdata", 32'(bus.rd_data), 32'h00);
    check("ovf_sticky",  32'(bus.overflow), 32'd1);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    check("ovf_clr",     32'(bus.overflow), 32'd0);

    // Pointer wrap.
    for (int i = 0; i < 12; i++) frame(8'h40 + 8'(i), 1'b0);
    check("wrap_count12", 32'(bus.count), 32'd12);
    for (int i = 0; i < 12; i++) pop_check("wrap_pop_a", 8'h40 + 8'(i));
    for (int i = 0; i < 8; i++) frame(8'h80 + 8'(i), 1'b0);
    check("wrap_count8", 32'(bus.count), 32'd8);
    for (int i = 0; i < 8; i++) pop_check("wrap_pop_b", 8'h80 + 8'(i));
    check("wrap_empty", 32'(bus.empty), 32'd1);

    // Push and pop on the same edge while full.
    for (int i = 0; i < 16; i++) frame(8'hC0 + 8'(i), 1'b0);
    check("sim_pre_full", 32'(bus.full), 32'd1);
    frame(8'hD0, 1'b1);
    check("sim_count", 32'(bus.count), 32'd16);
    check("sim_ovf",   32'(bus.overflow), 32'd0);
    check("sim_full",  32'(bus.full), 32'd1);
    for (int i = 1; i < 16; i++) pop_check("sim_drain", 8'hC0 + 8'(i));
    pop_check("sim_last", 8'hD0);
    check("sim_empty", 32'(bus.empty), 32'd1);

    // Reset while a capture is pending.
    frame(8'h55, 1'b0);
    check("mid_pre_count", 32'(bus.count), 32'd1);
    step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("mid_rst_count", 32'(bus.count), 32'd0);
    check("mid_rst_empty", 32'(bus.empty), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    check("mid_nostale1", 32'(bus.count), 32'd0);
    step(1'b0, 1'b1, 8'h77, 1'b0, 1'b0);
    check("mid_nostale2", 32'(bus.count), 32'd0);
    frame(8'h9A, 1'b0);
    check("mid_recover_cnt", 32'(bus.count), 32'd1);
    check("mid_recover_dat", 32'(bus.rd_data), 32'h9A);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
